// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine feeding the VGA framebuffer write port.
// It takes one command (x, y, w, h, colour), clips the rectangle to the
// screen and writes one cell per clock in row-major order. After the last
// cell it pulses done for one cycle.
module vga_rect_fill #(
  parameter int XW = 7,
  parameter int YW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XW-1:0]     cmd_x,
  input  logic [YW-1:0]     cmd_y,
  input  logic [XW:0]       cmd_w,
  input  logic [YW:0]       cmd_h,
  input  logic [3:0]        cmd_color,
  output logic [3:0]        adat,
  output logic [XW+YW-1:0]  adress,
  output logic              we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  // Screen dimensions, expressed one bit wider than the index so they are exact.
  localparam logic [XW:0] X_SPAN = {1'b1, {XW{1'b0}}};
  localparam logic [YW:0] Y_SPAN = {1'b1, {YW{1'b0}}};

  state_t            state_q;
  logic [XW-1:0]     x_q, col_q, col_last_q;
  logic [YW-1:0]     y_q, row_q, row_last_q;
  logic [3:0]        color_q;

  logic              cmd_ready_q, we_q, busy_q, done_q;
  logic [3:0]        adat_q;
  logic [XW+YW-1:0]  adress_q;

  // Clipped extents and the next cell, computed combinationally.
  logic [XW:0]       x_room_d, ew_d;
  logic [YW:0]       y_room_d, eh_d;
  logic [XW-1:0]     col_last_d, col_d, col_abs_d;
  logic [YW-1:0]     row_last_d, row_d, row_abs_d;
  logic              row_end_d, last_cell_d;

  // Clip the incoming command to the screen and step the cell counters.
  always_comb begin
    x_room_d    = X_SPAN - {1'b0, cmd_x};
    y_room_d    = Y_SPAN - {1'b0, cmd_y};
    ew_d        = (cmd_w < x_room_d) ? cmd_w : x_room_d;
    eh_d        = (cmd_h < y_room_d) ? cmd_h : y_room_d;
    // Low bits minus one gives the last index even when the extent is the
    // full span (e.g. 128 -> 0 - 1 -> 127); zero extents never reach FILL.
    col_last_d  = ew_d[XW-1:0] - 1'b1;
    row_last_d  = eh_d[YW-1:0] - 1'b1;
    row_end_d   = (col_q == col_last_q);
    last_cell_d = row_end_d && (row_q == row_last_q);
    col_d       = row_end_d ? '0 : col_q + 1'b1;
    row_d       = row_end_d ? row_q + 1'b1 : row_q;
    col_abs_d   = x_q + col_d;
    row_abs_d   = y_q + row_d;
  end

  // Control FSM with registered outputs; counters hold the cell on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      col_last_q  <= '0;
      row_last_q  <= '0;
      color_q     <= '0;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      adat_q      <= '0;
      adress_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            x_q         <= cmd_x;
            y_q         <= cmd_y;
            color_q     <= cmd_color;
            col_last_q  <= col_last_d;
            row_last_q  <= row_last_d;
            col_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            if ((ew_d == '0) || (eh_d == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= FILL;
              we_q     <= 1'b1;
              adat_q   <= cmd_color;
              adress_q <= {cmd_y, cmd_x};
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        FILL: begin
          if (last_cell_d) begin
            state_q <= DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            adat_q   <= color_q;
            adress_q <= {row_abs_d, col_abs_d};
          end
        end
        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign we        = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign adat      = adat_q;
  assign adress    = adress_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: fixed cases, clipping, zero size,
// full screen with busy rejection, mid-operation reset and random commands.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [7:0]  cmd_w = '0;
  logic [6:0]  cmd_h = '0;
  logic [3:0]  cmd_color = '0;
  logic [3:0]  adat;
  logic [12:0] adress;
  logic        we, busy, done;

  int checks = 0;
  int errors = 0;

  vga_rect_fill #(.XW(7), .YW(6)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .adat(adat), .adress(adress), .we(we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observations of one command, cycle 1 = first cycle after acceptance.
  logic [12:0] obs_a[$];
  logic [3:0]  obs_d[$];
  int          we_first, we_last, done_cyc, done_cnt, ready_cyc, extra_we;
  logic        acc_ready;
  int          exp_a[$];

  // Reference: every on-screen cell of the rectangle, row-major.
  function automatic void model_cells(int x, int y, int w, int h);
    exp_a.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if ((x + c < 128) && (y + r < 64))
          exp_a.push_back((y + r) * 128 + x + c);
  endfunction

  // Issue one command and record what the port does until cmd_ready returns.
  // When inj > 0, a different command is presented on cycles inj..inj+3.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int c, input int inj);
    obs_a.delete();
    obs_d.delete();
    we_first = -1; we_last = -1; done_cyc = -1; done_cnt = 0;
    ready_cyc = -1; extra_we = 0;
    @(negedge clk);
    acc_ready = cmd_ready;
    cmd_x = 7'(x); cmd_y = 6'(y); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_color = 4'(c); cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = 7'($urandom); cmd_y = 6'($urandom); cmd_w = 8'($urandom);
    cmd_h = 7'($urandom); cmd_color = 4'($urandom);
    for (int cyc = 1; cyc <= 9000; cyc++) begin
      if (we) begin
        obs_a.push_back(adress);
        obs_d.push_back(adat);
        if (we_first < 0) we_first = cyc;
        we_last = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cmd_ready) begin
        ready_cyc = cyc;
        break;
      end
      if (inj > 0 && cyc >= inj && cyc < inj + 4) begin
        cmd_valid = 1'b1; cmd_x = 7'd3; cmd_y = 6'd7; cmd_w = 8'd2;
        cmd_h = 7'd2; cmd_color = ~4'(c);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (we) extra_we++;
    end
    $display("cmd x=%0d y=%0d w=%0d h=%0d c=%0d writes=%0d done@%0d ready@%0d",
             x, y, w, h, c, obs_a.size(), done_cyc, ready_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, done, busy, cmd_ready} !== 4'b0000 || adat !== 4'd0 || adress !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b done=%b busy=%b ready=%b adat=%0d adr=%0d want all 0",
               we, done, busy, cmd_ready, adat, adress);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_fixed();
    int tx[2] = '{5, 126};
    int ty[2] = '{10, 63};
    int tw[2] = '{3, 4};
    int th[2] = '{2, 3};
    int tc[2] = '{10, 5};
    int k;
    for (int t = 0; t < 2; t++) begin
      model_cells(tx[t], ty[t], tw[t], th[t]);
      run_cmd(tx[t], ty[t], tw[t], th[t], tc[t], 0);
      k = exp_a.size();
      checks++;
      if (acc_ready !== 1'b1) begin errors++; $display("FAIL fixed%0d_accept got %b want 1", t, acc_ready); end
      checks++;
      if (obs_a.size() != k) begin errors++; $display("FAIL fixed%0d_count got %0d want %0d", t, obs_a.size(), k); end
      for (int i = 0; i < k && i < obs_a.size(); i++) begin
        checks++;
        if (obs_a[i] !== 13'(exp_a[i]) || obs_d[i] !== 4'(tc[t])) begin
          errors++;
          $display("FAIL fixed%0d_cell%0d got adr=%0d dat=%0d want adr=%0d dat=%0d",
                   t, i, obs_a[i], obs_d[i], exp_a[i], tc[t]);
        end
      end
      checks++;
      if (we_first != 1 || we_last != k) begin errors++; $display("FAIL fixed%0d_we_window got %0d..%0d want 1..%0d", t, we_first, we_last, k); end
      checks++;
      if (done_cyc != k + 1 || done_cnt != 1) begin errors++; $display("FAIL fixed%0d_done got cyc=%0d n=%0d want cyc=%0d n=1", t, done_cyc, done_cnt, k + 1); end
      checks++;
      if (ready_cyc != k + 2) begin errors++; $display("FAIL fixed%0d_ready got %0d want %0d", t, ready_cyc, k + 2); end
      checks++;
      if (extra_we != 0) begin errors++; $display("FAIL fixed%0d_extra_we got %0d want 0", t, extra_we); end
    end
  endtask

  task automatic test_zero();
    int tw[2] = '{0, 7};
    int th[2] = '{5, 0};
    for (int t = 0; t < 2; t++) begin
      run_cmd(20, 30, tw[t], th[t], 6, 0);
      checks++;
      if (obs_a.size() != 0) begin errors++; $display("FAIL zero%0d_writes got %0d want 0", t, obs_a.size()); end
      checks++;
      if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL zero%0d_done got cyc=%0d n=%0d want cyc=1 n=1", t, done_cyc, done_cnt); end
      checks++;
      if (ready_cyc != 2) begin errors++; $display("FAIL zero%0d_ready got %0d want 2", t, ready_cyc); end
    end
  endtask

  task automatic test_full_busy();
    int bad;
    model_cells(0, 0, 128, 64);
    run_cmd(0, 0, 128, 64, 3, 50);
    bad = 0;
    checks++;
    if (obs_a.size() != 8192) begin errors++; $display("FAIL full_count got %0d want 8192", obs_a.size()); end
    for (int i = 0; i < 8192 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 13'(exp_a[i]) || obs_d[i] !== 4'd3) begin
        errors++;
        if (bad < 5) $display("FAIL full_cell%0d got adr=%0d dat=%0d want adr=%0d dat=3", i, obs_a[i], obs_d[i], exp_a[i]);
        bad++;
      end
    end
    checks++;
    if (we_first != 1 || we_last != 8192) begin errors++; $display("FAIL full_we_window got %0d..%0d want 1..8192", we_first, we_last); end
    checks++;
    if (done_cyc != 8193 || done_cnt != 1) begin errors++; $display("FAIL full_done got cyc=%0d n=%0d want 8193 n=1", done_cyc, done_cnt); end
    checks++;
    if (ready_cyc != 8194) begin errors++; $display("FAIL full_ready got %0d want 8194", ready_cyc); end
    checks++;
    if (extra_we != 0) begin errors++; $display("FAIL busy_reject_extra_we got %0d want 0", extra_we); end
  endtask

  task automatic test_mid_reset();
    int n, dn, wn;
    @(negedge clk);
    cmd_x = 7'd0; cmd_y = 6'd0; cmd_w = 8'd128; cmd_h = 7'd64; cmd_color = 4'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (we) n++;
      if (n == 100) break;
      @(negedge clk);
    end
    checks++;
    if (n != 100 || adress !== 13'd99) begin
      errors++;
      $display("FAIL midrst_progress got writes=%0d adr=%0d want 100 / 99", n, adress);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || adress !== 13'd0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got we=%b busy=%b adr=%0d done=%b ready=%b want 0", we, busy, adress, done, cmd_ready);
    end
    rst = 1'b0;
    dn = 0; wn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
      if (we) wn++;
    end
    checks++;
    if (dn != 0 || wn != 0) begin errors++; $display("FAIL midrst_after got done=%0d we=%0d want 0/0", dn, wn); end
    run_cmd(0, 0, 1, 1, 9, 0);
    checks++;
    if (obs_a.size() != 1 || obs_a[0] !== 13'd0 || obs_d[0] !== 4'd9) begin
      errors++;
      $display("FAIL midrst_1x1 got n=%0d adr=%0d want n=1 adr=0", obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 13'h1fff);
    end
    checks++;
    if (done_cyc != 2 || ready_cyc != 3) begin errors++; $display("FAIL midrst_1x1_timing got done=%0d ready=%0d want 2/3", done_cyc, ready_cyc); end
  endtask

  task automatic test_random();
    int x, y, w, h, c, k;
    for (int t = 0; t < 15; t++) begin
      x = $urandom_range(0, 127);
      y = $urandom_range(0, 63);
      h = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(0, 6);
      w = ($urandom_range(0, 5) == 0 && h <= 6) ? 128 : $urandom_range(0, 20);
      if (t < 3) x = $urandom_range(115, 127);
      c = $urandom_range(0, 15);
      model_cells(x, y, w, h);
      run_cmd(x, y, w, h, c, 0);
      k = exp_a.size();
      checks++;
      if (obs_a.size() != k) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", t, obs_a.size(), k); end
      for (int i = 0; i < k && i < obs_a.size(); i++) begin
        checks++;
        if (obs_a[i] !== 13'(exp_a[i]) || obs_d[i] !== 4'(c)) begin
          errors++;
          $display("FAIL rand%0d_cell%0d got adr=%0d dat=%0d want adr=%0d dat=%0d", t, i, obs_a[i], obs_d[i], exp_a[i], c);
        end
      end
      if (k > 0) begin
        checks++;
        if (we_first != 1 || we_last != k) begin errors++; $display("FAIL rand%0d_we_window got %0d..%0d want 1..%0d", t, we_first, we_last, k); end
      end
      checks++;
      if (done_cyc != k + 1 || done_cnt != 1) begin errors++; $display("FAIL rand%0d_done got cyc=%0d n=%0d want cyc=%0d n=1", t, done_cyc, done_cnt, k + 1); end
      checks++;
      if (ready_cyc != k + 2) begin errors++; $display("FAIL rand%0d_ready got %0d want %0d", t, ready_cyc, k + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_zero();
    test_full_busy();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle-fill engine that sits directly upstream of the VGA display block and drives its framebuffer write port (`adat`, `adress`, `we`). It accepts one rectangle command at a time with position, size and a 4-bit colour. It then writes that colour into every covered framebuffer cell, one cell per clock, in row-major order. Screen clears, background fills and solid sprites are built from this block.

## Interface
Parameters:
- `XW`, 7: column index width; the framebuffer is 2^XW = 128 columns.
- `YW`, 6: row index width; the framebuffer is 2^YW = 64 rows. `XW+YW` must equal 13, the `adress` width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  the block can accept a command.
- `cmd_x`  in  XW  left column.
- `cmd_y`  in  YW  top row.
- `cmd_w`  in  XW+1  width in cells, 0..128.
- `cmd_h`  in  YW+1  height in cells, 0..64.
- `cmd_color`  in  4  fill colour.
- `adat`  out  4  write data to the framebuffer.
- `adress`  out  13  write address = {row, col}, i.e. row*128+col.
- `we`  out  1  write strobe; one cell per cycle while high.
- `busy`  out  1  high from command acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FILL, DONE.
- IDLE: `cmd_ready`=1. A command is accepted on a clock edge where `cmd_valid`&&`cmd_ready`.
- On acceptance the block latches the x, y and colour fields. It also computes and latches the clipped extents:
  - `ew` = min(`cmd_w`, 128−`cmd_x`)
  - `eh` = min(`cmd_h`, 64−`cmd_y`)
  - The arithmetic is unsigned and one bit wider than the index, so there is no wrap-around.
- If `ew`=0 or `eh`=0, the next state is DONE and no writes occur. Otherwise the next state is FILL.
- FILL:
  - The column counter runs 0..`ew`−1. At `ew`−1 it returns to 0 and the row counter increments.
  - After cell (`eh`−1, `ew`−1) is written, the next state is DONE.
  - `adress` = {`cmd_y`+row, `cmd_x`+col}, `adat` = colour, `we`=1 on every FILL cycle.
  - Clipped cells are never visited and never written. Addresses never wrap across a row edge or past 8191.
- DONE: `done`=1 for one cycle, then IDLE.
- `cmd_valid` outside IDLE is ignored: not latched and not queued. Command inputs need only be stable in the accepting cycle.
- Reset mid-operation:
  - On the next edge, the state is IDLE and all outputs take their reset values.
  - The remaining cells of the abandoned rectangle are not written.
  - No `done` pulse is issued for the abandoned command.

## Timing
- Reset values: `we`=0, `adat`=0, `adress`=0, `done`=0, `busy`=0, `cmd_ready`=0 while `rst` is high.
- `cmd_ready`=1 from the first cycle after `rst` deasserts.
- All outputs are registered. `cmd_ready` = (state==IDLE).
- Numbering the acceptance edge as cycle N:
  - `we` is high on cycles N+1 .. N+ew·eh, exactly ew·eh consecutive cycles with no gaps.
  - `done` is high on cycle N+ew·eh+1.
  - `cmd_ready` returns to 1 on cycle N+ew·eh+2.
- Zero-size command: `done` on cycle N+1 and `cmd_ready` on cycle N+2.
- Throughput: one cell per clock. Commands are spaced by at least ew·eh+2 cycles.
- `adat`/`adress` hold their last driven values when `we`=0. The downstream block samples only while `we`=1.
- `busy` = (state≠IDLE).

## Test plan
- Rectangle (x=5, y=10, w=3, h=2, colour=0xA): `we` is high for exactly 6 cycles with `adat`=0xA and addresses 1285, 1286, 1287, 1413, 1414, 1415 in that order. `done` follows on the 7th cycle after acceptance.
- Clipping (x=126, y=63, w=4, h=3, colour=0x5): exactly 2 writes, to 8190 then 8191, followed by `done`. No address wraps.
- Zero size (w=0, h=5), then (w=7, h=0): each gives no `we` and `done` exactly 1 cycle after acceptance.
- Full screen (x=0, y=0, w=128, h=64, colour=0x3): 8192 consecutive writes covering addresses 0..8191 ascending, each exactly once. `done` comes at N+8193.
- Busy rejection: during the full-screen fill, pulse `cmd_valid` with a different command. `cmd_ready` stays 0, the write sequence is unchanged, and nothing is written after `done`.
- Mid-operation reset: assert `rst` for 1 cycle after 100 writes of the full-screen fill. The next edge shows `we`=0, `busy`=0 and `adress`=0, and no `done` follows. A new 1×1 command at (0,0) then writes only address 0.
